mod_count_bcd_conv: RTL and testbench

- Sequential binary-to-BCD converter (shift-add-3 / double-dabble) sitting directly downstream of the modulus counter.
- Takes the counter's binary value Q on a start request and produces packed BCD digits for the display/digit-mux stage.
- One shift per clock. Holds the last result until the next conversion completes.

---
 rtl/mod_count_bcd_conv_if.sv | 15 +
 rtl/mod_count_bcd_conv.sv | 97 +++++++++
 tb/tb_mod_count_bcd_conv.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/mod_count_bcd_conv_if.sv
// Handshake bundle between the modulus counter side and the binary-to-BCD converter.
interface mod_count_bcd_conv_if #(
  parameter int W      = 6,
  parameter int DIGITS = 2
);
  logic [W-1:0]        bin;
  logic                start;
  logic                busy;
  logic                done;
  logic [4*DIGITS-1:0] bcd;
  logic                ovf;

  modport master (output bin, output start, input busy, input done, input bcd, input ovf);
  modport slave  (input bin, input start, output busy, output done, output bcd, output ovf);
endinterface

// File: rtl/mod_count_bcd_conv.sv
// Sequential double-dabble binary-to-BCD converter, one shift per clock.
// Define BCD_OVF_CLAMP_EN to flag inputs above 10^DIGITS-1 and clamp the result to all 9s.
module mod_count_bcd_conv #(
  parameter int W      = 6,
  parameter int DIGITS = 2
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  mod_count_bcd_conv_if.slave  io
);
  localparam int SW = 4*DIGITS + W;
  localparam int CW = $clog2(W+1);
  localparam logic [CW-1:0] CNT_LAST = CW'(W-1);

  typedef enum logic {S_IDLE, S_SHIFT} state_t;

  state_t              r_state;
  logic [SW-1:0]       r_sr;
  logic [CW-1:0]       r_cnt;
  logic                r_busy;
  logic                r_done;
  logic [4*DIGITS-1:0] r_bcd;
  logic [SW-1:0]       w_adj;
  logic [SW-1:0]       w_shift;

`ifdef BCD_OVF_CLAMP_EN
  localparam int unsigned MAXV = 10**DIGITS - 1;
  localparam logic [4*DIGITS-1:0] NINES = {DIGITS{4'h9}};
  logic r_clamp;
  logic r_ovf;
  logic w_gt;
  assign w_gt   = (32'(io.bin) > MAXV);
  assign io.ovf = r_ovf;
`else
  assign io.ovf = 1'b0;
`endif

  // Add-3 on every digit field >= 5, all digits in parallel, before the shift.
  always_comb begin
    w_adj = r_sr;
    for (int d = 0; d < DIGITS; d++) begin
      if (r_sr[W+4*d +: 4] >= 4'd5)
        w_adj[W+4*d +: 4] = r_sr[W+4*d +: 4] + 4'd3;
    end
    w_shift = {w_adj[SW-2:0], 1'b0};
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state <= S_IDLE;
      r_sr    <= '0;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_bcd   <= '0;
`ifdef BCD_OVF_CLAMP_EN
      r_clamp <= 1'b0;
      r_ovf   <= 1'b0;
`endif
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (io.start) begin
            r_sr    <= {{(4*DIGITS){1'b0}}, io.bin};
            r_cnt   <= '0;
            r_busy  <= 1'b1;
            r_state <= S_SHIFT;
`ifdef BCD_OVF_CLAMP_EN
            r_clamp <= w_gt;
`endif
          end
        end
        S_SHIFT: begin
          r_sr  <= w_shift;
          r_cnt <= r_cnt + CW'(1);
          if (r_cnt == CNT_LAST) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
`ifdef BCD_OVF_CLAMP_EN
            r_ovf   <= r_clamp;
            r_bcd   <= r_clamp ? NINES : w_shift[SW-1:W];
`else
            r_bcd   <= w_shift[SW-1:W];
`endif
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign io.busy = r_busy;
  assign io.done = r_done;
  assign io.bcd  = r_bcd;
endmodule

// File: tb/tb_mod_count_bcd_conv.sv
// Scoreboard bench for mod_count_bcd_conv: W=6 and W=7 instances, directed vectors.
module tb_mod_count_bcd_conv;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;

  typedef struct {
    logic [7:0] bcd;
    logic       ovf;
    int         due;
  } exp_t;

  exp_t q6[$];
  exp_t q7[$];

  mod_count_bcd_conv_if #(.W(6), .DIGITS(2)) if6 ();
  mod_count_bcd_conv_if #(.W(7), .DIGITS(2)) if7 ();

  mod_count_bcd_conv #(.W(6), .DIGITS(2)) u6 (.i_clk(clk), .i_reset(reset), .io(if6));
  mod_count_bcd_conv #(.W(7), .DIGITS(2)) u7 (.i_clk(clk), .i_reset(reset), .io(if7));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitors: pop an expectation on every done pulse.
  always @(negedge clk) begin
    if (!reset && if6.done) begin
      checks++;
      if (q6.size() == 0) begin
        errors++;
        $display("FAIL dut6_unexpected_done bcd=%h cyc=%0d", if6.bcd, cyc);
      end else begin
        exp_t e;
        e = q6.pop_front();
        if (if6.bcd !== e.bcd || if6.ovf !== e.ovf || cyc != e.due) begin
          errors++;
          $display("FAIL dut6_result got bcd=%h ovf=%b cyc=%0d want bcd=%h ovf=%b cyc=%0d",
                   if6.bcd, if6.ovf, cyc, e.bcd, e.ovf, e.due);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (!reset && if7.done) begin
      checks++;
      if (q7.size() == 0) begin
        errors++;
        $display("FAIL dut7_unexpected_done bcd=%h cyc=%0d", if7.bcd, cyc);
      end else begin
        exp_t e;
        e = q7.pop_front();
        if (if7.bcd !== e.bcd || if7.ovf !== e.ovf || cyc != e.due) begin
          errors++;
          $display("FAIL dut7_result got bcd=%h ovf=%b cyc=%0d want bcd=%h ovf=%b cyc=%0d",
                   if7.bcd, if7.ovf, cyc, e.bcd, e.ovf, e.due);
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%h want=%h", name, got, want);
    end
  endtask

  // Called at a negedge; start is high across exactly one rising edge.
  task automatic start6(input logic [5:0] b, input logic [7:0] e_bcd, input bit expect_it);
    if6.bin   = b;
    if6.start = 1'b1;
    if (expect_it) q6.push_back('{e_bcd, 1'b0, cyc + 1 + 6});
    @(negedge clk);
    if6.start = 1'b0;
  endtask

  task automatic start7(input logic [6:0] b, input logic [7:0] e_bcd, input logic e_ovf);
    if7.bin   = b;
    if7.start = 1'b1;
    q7.push_back('{e_bcd, e_ovf, cyc + 1 + 7});
    @(negedge clk);
    if7.start = 1'b0;
  endtask

  task automatic wait_idle6();
    int n = 0;
    while (if6.busy && n < 30) begin
      @(negedge clk);
      n++;
    end
    if (if6.busy) begin
      errors++;
      $display("FAIL dut6_idle_timeout busy=%b", if6.busy);
    end
    @(negedge clk);
  endtask

  task automatic wait_idle7();
    int n = 0;
    while (if7.busy && n < 30) begin
      @(negedge clk);
      n++;
    end
    if (if7.busy) begin
      errors++;
      $display("FAIL dut7_idle_timeout busy=%b", if7.busy);
    end
    @(negedge clk);
  endtask

  initial begin
    int n;
    logic bad;
    if6.bin = '0; if6.start = 1'b0;
    if7.bin = '0; if7.start = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;

    // Idle after reset with no start.
    bad = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (if6.bcd !== 8'h00 || if6.busy !== 1'b0 || if6.done !== 1'b0 || if6.ovf !== 1'b0 ||
          if7.bcd !== 8'h00 || if7.busy !== 1'b0 || if7.done !== 1'b0 || if7.ovf !== 1'b0)
        bad = 1'b1;
    end
    check("reset_idle_outputs", {31'd0, bad}, 32'd0);

    // bin=53: busy for 6 cycles, done at k+6, gone at k+7.
    start6(6'd53, 8'h53, 1'b1);
    n = 1;
    while (if6.busy && n < 20) begin
      @(negedge clk);
      if (if6.busy) n++;
    end
    check("busy_cycles_53", n, 6);
    check("done_at_k6", {31'd0, if6.done}, 32'd1);
    @(negedge clk);
    check("done_low_k7", {31'd0, if6.done}, 32'd0);
    check("bcd_hold_53", {24'd0, if6.bcd}, 32'h53);

    // Back-to-back sweep, each new start in the done cycle.
    start6(6'd0, 8'h00, 1'b1);
    for (int b = 1; b <= 52; b++) begin
      n = 0;
      do begin
        @(negedge clk);
        n++;
      end while (!if6.done && n < 20);
      if (!if6.done) begin
        errors++;
        $display("FAIL sweep_done_timeout bin=%0d", b);
      end
      start6(6'(b), 8'(((b / 10) << 4) | (b % 10)), 1'b1);
    end
    wait_idle6();

    // Second start during busy is ignored.
    start6(6'd21, 8'h21, 1'b1);
    @(negedge clk);
    @(negedge clk);
    start6(6'd40, 8'h40, 1'b0);
    wait_idle6();
    repeat (8) @(negedge clk);
    check("ignored_start_bcd", {24'd0, if6.bcd}, 32'h21);

    // Reset mid-conversion: immediate clear, no done.
    start6(6'd45, 8'h45, 1'b0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("rst_mid_bcd",  {24'd0, if6.bcd}, 32'h00);
    check("rst_mid_busy", {31'd0, if6.busy}, 32'd0);
    check("rst_mid_done", {31'd0, if6.done}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    bad = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (if6.done !== 1'b0 || if6.busy !== 1'b0) bad = 1'b1;
    end
    check("rst_no_done", {31'd0, bad}, 32'd0);
    start6(6'd37, 8'h37, 1'b1);
    wait_idle6();

    // W=7 instance: overflow handling and boundary at 99.
`ifdef BCD_OVF_CLAMP_EN
    start7(7'd123, 8'h99, 1'b1);
    wait_idle7();
    start7(7'd100, 8'h99, 1'b1);
    wait_idle7();
`else
    start7(7'd123, 8'h23, 1'b0);
    wait_idle7();
    start7(7'd100, 8'h00, 1'b0);
    wait_idle7();
`endif
    start7(7'd99, 8'h99, 1'b0);
    wait_idle7();
    start7(7'd68, 8'h68, 1'b0);
    wait_idle7();

    repeat (10) @(negedge clk);
    check("q6_drained", q6.size(), 0);
    check("q7_drained", q7.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout cyc=%0d", cyc);
    $fatal(1, "timeout");
  end
endmodule
